// File: rtl/qspi_arb.sv
// qspi_arb: two-port arbiter sharing one QSPI engine between icache line
// fills and dcache fills/writebacks. Round-robin on ties, one-cycle
// chip-select gap between transactions, all outputs registered.
// Optional watchdog compiled in with `define QSPI_ARB_WDOG_EN.
module qspi_arb #(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    parameter int WDOG_CYCLES = 255,
    localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [TW-1:0] i_tag,
    input  logic          d_req,
    input  logic          d_write,
    input  logic [TW-1:0] d_tag,
    input  logic          d_mem,
    input  logic          q_done,
    output logic          q_req,
    output logic          q_i_d,
    output logic          q_write,
    output logic          q_mem,
    output logic [TW-1:0] q_tag,
    output logic          i_gnt,
    output logic          d_gnt,
    output logic          i_done,
    output logic          d_done,
`ifdef QSPI_ARB_WDOG_EN
    output logic          wdog_err,
`endif
    output logic          busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0] state;
    logic       last_d;
    logic       end_grant;
    logic       in_grant;

    assign in_grant = (state == GNT_I) || (state == GNT_D);

    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_wdog_range
        $error("qspi_arb: WDOG_CYCLES must be within 1..255");
    end

`ifdef QSPI_ARB_WDOG_EN
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    logic [7:0] wdog_cnt;
    logic       timeout;

    // A grant is forced to end once it has been held for WDOG_CYCLES clocks.
    assign timeout   = in_grant && (wdog_cnt == WDOG_LAST);
    assign end_grant = q_done || timeout;

    // Watchdog counter runs only while a grant is held; sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= 8'd0;
            wdog_err <= 1'b0;
        end else begin
            if (in_grant && !end_grant)
                wdog_cnt <= wdog_cnt + 8'd1;
            else
                wdog_cnt <= 8'd0;
            if (timeout && !q_done)
                wdog_err <= 1'b1;
        end
    end
`else
    assign end_grant = q_done;
`endif

    // Arbitration FSM with registered grant, attribute and done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            q_req   <= 1'b0;
            q_i_d   <= 1'b0;
            q_write <= 1'b0;
            q_mem   <= 1'b0;
            q_tag   <= '0;
            i_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req && (!d_req || last_d)) begin
                        state   <= GNT_I;
                        i_gnt   <= 1'b1;
                        q_req   <= 1'b1;
                        q_i_d   <= 1'b1;
                        q_write <= 1'b0;
                        q_mem   <= 1'b1;
                        q_tag   <= i_tag;
                        busy    <= 1'b1;
                    end else if (d_req) begin
                        state   <= GNT_D;
                        d_gnt   <= 1'b1;
                        q_req   <= 1'b1;
                        q_i_d   <= 1'b0;
                        q_write <= d_write;
                        q_mem   <= d_mem & ~d_write;
                        q_tag   <= d_tag;
                        busy    <= 1'b1;
                    end
                end
                GNT_I: begin
                    if (end_grant) begin
                        state  <= GAP;
                        q_req  <= 1'b0;
                        i_gnt  <= 1'b0;
                        i_done <= 1'b1;
                        last_d <= 1'b0;
                    end
                end
                GNT_D: begin
                    if (end_grant) begin
                        state  <= GAP;
                        q_req  <= 1'b0;
                        d_gnt  <= 1'b0;
                        d_done <= 1'b1;
                        last_d <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: directed scoreboard bench for qspi_arb. Stimulus pushes the
// expected grant attributes and done owner into queues; a negedge monitor
// pops and compares whenever a grant rises or a done pulse appears.
module tb_qspi_arb;

    localparam int TW = 20;
`ifdef QSPI_ARB_WDOG_EN
    localparam int WDOG = 10;
`else
    localparam int WDOG = 255;
`endif

    typedef struct packed {
        logic          is_d;
        logic          i_d;
        logic          wr;
        logic          mem;
        logic [TW-1:0] tag;
    } grant_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [TW-1:0] i_tag = '0;
    logic          d_req = 1'b0;
    logic          d_write = 1'b0;
    logic [TW-1:0] d_tag = '0;
    logic          d_mem = 1'b0;
    logic          q_done = 1'b0;
    logic          q_req, q_i_d, q_write, q_mem;
    logic [TW-1:0] q_tag;
    logic          i_gnt, d_gnt, i_done, d_done, busy;
`ifdef QSPI_ARB_WDOG_EN
    logic          wdog_err;
`endif

    int     n_cmp = 0;
    int     n_err = 0;
    grant_t gq[$];
    logic   dq[$];
    grant_t cur;
    logic   prev_gnt = 1'b0;
    logic   gnt_now;
    logic   exp_d;

    qspi_arb #(.PA(22), .LINE_LENGTH(4), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_tag(i_tag),
        .d_req(d_req), .d_write(d_write), .d_tag(d_tag), .d_mem(d_mem),
        .q_done(q_done), .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write),
        .q_mem(q_mem), .q_tag(q_tag), .i_gnt(i_gnt), .d_gnt(d_gnt),
        .i_done(i_done), .d_done(d_done),
`ifdef QSPI_ARB_WDOG_EN
        .wdog_err(wdog_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic is_d, input logic wr, input logic mem, input logic [TW-1:0] tag);
        grant_t g;
        g.is_d = is_d;
        g.i_d  = !is_d;
        g.wr   = is_d ? wr : 1'b0;
        g.mem  = is_d ? (mem & ~wr) : 1'b1;
        g.tag  = tag;
        gq.push_back(g);
        if (is_d) begin
            d_req = 1'b1; d_write = wr; d_mem = mem; d_tag = tag;
        end else begin
            i_req = 1'b1; i_tag = tag;
        end
    endtask

    function automatic logic [63:0] grant_vec(input grant_t g);
        return 64'({g.is_d, !g.is_d, 1'b1, g.i_d, g.wr, g.mem, g.tag});
    endfunction

    // Scoreboard monitor: compares on grant rise, while granted, and on done.
    always @(negedge clk) begin
        gnt_now = i_gnt | d_gnt;
        if (gnt_now && !prev_gnt) begin
            if (gq.size() == 0) begin
                n_cmp++; n_err++;
                $display("[TB] FAIL unexpected_grant: got i_gnt=%0b d_gnt=%0b expected none", i_gnt, d_gnt);
            end else begin
                cur = gq.pop_front();
                check_output("grant_attrs", 64'({d_gnt, i_gnt, q_req, q_i_d, q_write, q_mem, q_tag}), grant_vec(cur));
            end
        end else if (gnt_now) begin
            check_output("attrs_stable", 64'({d_gnt, i_gnt, q_req, q_i_d, q_write, q_mem, q_tag}), grant_vec(cur));
        end
        if (i_done | d_done) begin
            if (dq.size() == 0) begin
                n_cmp++; n_err++;
                $display("[TB] FAIL unexpected_done: got i_done=%0b d_done=%0b expected none", i_done, d_done);
            end else begin
                exp_d = dq.pop_front();
                check_output("done_pulse", 64'({i_done, d_done, q_req, i_gnt, d_gnt, busy}),
                             64'({!exp_d, exp_d, 1'b0, 1'b0, 1'b0, 1'b1}));
            end
        end
        prev_gnt = gnt_now;
    end

    initial begin
        int n;
        // Reset state
        tick(3);
        check_output("reset_outputs", 64'({busy, q_req, q_i_d, q_write, q_mem, q_tag, i_gnt, d_gnt, i_done, d_done}), 64'd0);
        reset = 1'b1;
        tick(1);

        // Lone icache fill, q_done six cycles after q_req rises
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'h01234);
        dq.push_back(1'b0);
        tick(1);
        check_output("i_grant_latency", 64'({i_gnt, q_req, q_i_d, q_tag}), 64'({1'b1, 1'b1, 1'b1, 20'h01234}));
        tick(5);
        q_done = 1'b1; i_req = 1'b0;
        tick(1);
        q_done = 1'b0;
        check_output("gap_cycle", 64'({q_req, busy, i_gnt}), 64'({1'b0, 1'b1, 1'b0}));
        tick(1);
        check_output("back_to_idle", 64'({busy, q_req, i_done}), 64'd0);

        // Dcache writeback to ROM space; inputs change mid-grant
        apply_stimulus(1'b1, 1'b1, 1'b1, 20'h00ABC);
        dq.push_back(1'b1);
        tick(1);
        d_tag = 20'h3FFFF; d_write = 1'b0; d_mem = 1'b0;
        tick(3);
        q_done = 1'b1; d_req = 1'b0;
        tick(1);
        q_done = 1'b0;
        tick(1);

        // Stray q_done in IDLE, then requester drops mid-grant
        q_done = 1'b1;
        tick(1);
        q_done = 1'b0;
        check_output("stray_done_idle", 64'({busy, q_req, i_gnt, d_gnt}), 64'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'h00055);
        dq.push_back(1'b0);
        tick(1);
        i_req = 1'b0;
        tick(4);
        check_output("held_after_drop", 64'({i_gnt, q_req, busy}), 64'({1'b1, 1'b1, 1'b1}));
        q_done = 1'b1;
        tick(2);
        q_done = 1'b0;
        check_output("done_in_gap_ignored", 64'({busy, q_req, i_gnt, i_done}), 64'd0);

        // Both requesters held from reset release: I, D, I, D
        reset = 1'b0;
        tick(2);
        gq.push_back(grant_t'({1'b0, 1'b1, 1'b0, 1'b1, 20'h11111}));
        gq.push_back(grant_t'({1'b1, 1'b0, 1'b0, 1'b1, 20'h22222}));
        gq.push_back(grant_t'({1'b0, 1'b1, 1'b0, 1'b1, 20'h11111}));
        gq.push_back(grant_t'({1'b1, 1'b0, 1'b0, 1'b1, 20'h22222}));
        dq.push_back(1'b0); dq.push_back(1'b1); dq.push_back(1'b0); dq.push_back(1'b1);
        i_req = 1'b1; i_tag = 20'h11111;
        d_req = 1'b1; d_tag = 20'h22222; d_write = 1'b0; d_mem = 1'b1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(i_gnt | d_gnt) && n < 20) begin
                tick(1);
                n++;
            end
            if (n >= 20) begin
                n_cmp++; n_err++;
                $display("[TB] FAIL grant_timeout: got no grant in 20 cycles expected grant %0d", k);
            end
            tick(2);
            q_done = 1'b1;
            tick(1);
            q_done = 1'b0;
            if (k == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            check_output("rr_gap", 64'({q_req, i_gnt, d_gnt, busy}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
            tick(1);
            check_output("rr_idle", 64'({q_req, busy}), 64'd0);
        end

`ifdef QSPI_ARB_WDOG_EN
        // Watchdog ends a grant that never sees q_done
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'h00777);
        dq.push_back(1'b0);
        tick(1);
        i_req = 1'b0;
        tick(8);
        check_output("wdog_before", 64'({i_gnt, wdog_err}), 64'({1'b1, 1'b0}));
        tick(1);
        check_output("wdog_fire", 64'({i_gnt, i_done, wdog_err}), 64'({1'b0, 1'b1, 1'b1}));
        tick(3);
        check_output("wdog_sticky", 64'({wdog_err, busy}), 64'({1'b1, 1'b0}));
        reset = 1'b0;
        tick(1);
        check_output("wdog_cleared", 64'(wdog_err), 64'd0);
        reset = 1'b1;
        tick(1);
`endif

        // Asynchronous reset during a dcache fill: no done pulse
        apply_stimulus(1'b1, 1'b0, 1'b0, 20'h0F0F0);
        tick(1);
        d_req = 1'b0;
        tick(2);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_reset_abort", 64'({busy, q_req, q_i_d, q_write, q_mem, q_tag, i_gnt, d_gnt, i_done, d_done}), 64'd0);
        tick(2);
        reset = 1'b1;
        tick(3);
        check_output("queues_drained", 64'({gq.size(), dq.size()}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
